interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Priority interrupt controller directly downstream of the system timer and other peripherals.
//  Collects up to 8 interrupt lines and applies mask, trigger mode and fixed priority (line 0 highest).
//  Presents a single cpu_irq plus a 3-bit vector to the CPU, with an acknowledge handshake and nested in-service tracking.
//  Timer interrupt is wired to irq_in[0]. The CPU interface is the same 8-bit cs/read/write register bus as the other I/O blocks.
// PARAMETERS
//  NUM_IRQ      8   number of active lines, 1..8; irq_in bits >= NUM_IRQ are ignored (read as 0)
//  SYNC_STAGES  2   synchronizer flops on each irq_in bit, >= 2
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst_n     in   1  asynchronous active-low reset
//  addr      in   3  register select
//  data_in   in   8  write data
//  data_out  out  8  read data, combinational mux on addr (independent of cs/read)
//  read      in   1  read strobe (no side effects on read)
//  write     in   1  write strobe, qualified by cs
//  cs        in   1  chip select
//  irq_in    in   8  interrupt requests, asynchronous, active-high
//  cpu_irq   out  1  registered request to CPU
//  cpu_ack   in   1  one-cycle CPU acknowledge
//  vector    out  3  index of the line being requested, registered, stable while cpu_irq=1
// BEHAVIOUR
//  Registers:
//   0 IMR      RW  1 = line enabled; reset 0x00
//   1 PENDING  R   pending bits; W1C clears edge-mode bits only
//   2 ISR      R   in-service bits; writes ignored
//   3 TRIG     RW  1 = rising-edge, 0 = level; reset 0xFF
//   4 EOI      W   any write clears the highest-priority (lowest index) set ISR bit; reads 0x00
//   5 VECTOR   R   {5'b0, vector}
//   6 CTRL     RW  bit0 = global enable, other bits read 0; reset 0x00
//   7          reads 0x00, writes ignored
//  Reset values: pending/ISR/sync flops = 0; state IDLE; cpu_irq = 0; vector = 0.
//  Synchronization and pending:
//   - irq_in passes through SYNC_STAGES flops -> s.
//   - Edge mode: pending set when s rises (s & ~s_prev); held until ack or W1C. Set wins over a same-cycle W1C.
//   - Level mode: pending = s (live); W1C has no effect.
//  Candidate:
//   - cand = pending & IMR & {8{CTRL[0]}}.
//   - best = lowest set index of cand.
//   - Eligible only if best < lowest set ISR index, or ISR == 0 (nesting: only strictly higher priority preempts).
//  FSM (registered):
//   - IDLE: eligible -> REQ; cpu_irq<=1, vector<=best.
//   - REQ:
//     - cpu_ack -> IDLE; ISR[vector]<=1; if TRIG[vector], clear pending[vector]; cpu_irq<=0 next edge.
//     - Else if no longer eligible (masked, disabled, level dropped, or W1C) -> IDLE; cpu_irq<=0. No ISR change.
//     - Else a higher-priority eligible line appears -> vector<=new best, stay REQ.
//   - cpu_ack in IDLE is ignored.
//   - A new request cannot assert cpu_irq in the same cycle as an ack; earliest is 1 cycle after returning to IDLE.
//  Latency: irq_in high before edge 1 (SYNC_STAGES=2) -> pending at edge 3 -> cpu_irq=1 after edge 4.
//  EOI with ISR=0: no effect. EOI in same cycle as ack: ack sets ISR[vector] first, then EOI clears the lowest set ISR bit.
//  IMR/CTRL changes take effect on the cpu_irq evaluation of the next edge.
//  Async reset mid-handshake: everything returns to reset values; cpu_irq drops immediately.
// TESTING
//  1. IMR=0x01, CTRL=1, TRIG=0xFF, pulse irq_in[0] 1 cycle
//     -> cpu_irq=1, vector=0 four cycles later; ack -> ISR=0x01, PENDING=0x00, cpu_irq=0; EOI -> ISR=0x00.
//  2. IMR=0xFF, CTRL=1, pulse irq_in[5] and irq_in[2] together
//     -> vector=2; ack -> ISR=0x04; vector then 5 only after EOI, since 5 is lower priority than in-service 2.
//  3. Nesting: line 4 in service (ISR=0x10), pulse irq_in[1]
//     -> cpu_irq=1, vector=1; ack -> ISR=0x12; EOI -> ISR=0x10; EOI -> ISR=0x00.
//  4. TRIG[3]=0 level, hold irq_in[3]=1 -> cpu_irq=1; drop irq_in[3] before ack
//     -> cpu_irq=0 and ISR unchanged; ack while IDLE -> no effect.
//  5. Edge pending on line 6 with IMR=0 -> PENDING=0x40, cpu_irq=0; write PENDING=0x40 -> 0x00;
//     repeat with a new edge in the same cycle as the W1C -> PENDING stays 0x40.
//  6. Assert rst_n=0 while cpu_irq=1 -> cpu_irq=0 immediately; IMR=0, TRIG=0xFF, ISR=0, PENDING=0.

Source files
------------

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//   Priority interrupt controller for up to 8 request lines. Each line is
//   synchronized, then handled as rising-edge or level triggered, masked and
//   globally enabled. Line 0 has the highest priority. The controller raises a
//   single registered cpu_irq with a 3-bit vector. It tracks in-service lines
//   so that only a strictly higher-priority line can preempt a handler.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   addr      register select (0..7)
//   data_in   write data
//   data_out  read data, combinational on addr
//   read      read strobe (reads have no side effects)
//   write     write strobe, qualified by cs
//   cs        chip select
//   irq_in    asynchronous active-high interrupt requests
//   cpu_irq   registered interrupt request to the CPU
//   cpu_ack   one-cycle acknowledge from the CPU
//   vector    index of the requested line, stable while cpu_irq=1
//
// Register map
//   0 IMR  1 VECTOR-pending (PENDING, W1C on edge bits)  2 ISR  3 TRIG
//   4 EOI  5 VECTOR  6 CTRL (bit0 global enable)  7 unused
// -----------------------------------------------------------------------------
module interrupt_controller #(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       read,
   input  logic       write,
   input  logic       cs,
   input  logic [7:0] irq_in,
   output logic       cpu_irq,
   input  logic       cpu_ack,
   output logic [2:0] vector
);

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t     state_reg, state_next;
   logic [7:0] sync_reg [SYNC_STAGES];
   logic [7:0] s_prev_reg;
   logic [7:0] imr_reg, imr_next;
   logic [7:0] trig_reg, trig_next;
   logic       ctrl_en_reg, ctrl_en_next;
   logic [7:0] edge_pend_reg, edge_pend_next;
   logic [7:0] isr_reg, isr_next;
   logic       cpu_irq_reg, cpu_irq_next;
   logic [2:0] vector_reg, vector_next;

   logic [7:0] line_mask;
   logic [7:0] s;
   logic       wr_en;
   logic       eoi;
   logic [7:0] w1c;
   logic [7:0] pending;
   logic [7:0] cand;
   logic [7:0] isr_low;
   logic [7:0] allow;
   logic [7:0] elig;
   logic       eligible;
   logic [2:0] best;
   logic       ack_fire;
   logic [7:0] vec_onehot;
   logic [7:0] isr_acked;
   logic [7:0] edge_set, edge_clr;

   // Lines at or above NUM_IRQ are tied off after the synchronizer.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_line_mask
         assign line_mask[gi] = (gi < NUM_IRQ);
      end
   endgenerate

   assign s        = sync_reg[SYNC_STAGES-1] & line_mask;
   assign wr_en    = cs & write;
   assign eoi      = wr_en && (addr == 3'd4);
   assign w1c      = (wr_en && (addr == 3'd1)) ? data_in : 8'h00;

   // Edge lines report the latched bit, level lines report the live input.
   assign pending  = (edge_pend_reg & trig_reg) | (s & ~trig_reg);
   assign cand     = pending & imr_reg & {8{ctrl_en_reg}};

   // Only lines strictly above the highest-priority in-service line may
   // request: the bits below the lowest set ISR bit.
   assign isr_low  = isr_reg & (~isr_reg + 8'd1);
   assign allow    = (isr_reg == 8'h00) ? 8'hFF : (isr_low - 8'd1);
   assign elig     = cand & allow;
   assign eligible = |elig;

   always_comb begin
      best = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (elig[i]) best = 3'(i);
      end
   end

   assign ack_fire   = (state_reg == ST_REQ) && cpu_ack;
   assign vec_onehot = 8'd1 << vector_reg;

   // A fresh edge wins over a same-cycle W1C or ack clear.
   assign edge_set = s & ~s_prev_reg & trig_reg;
   assign edge_clr = w1c | (ack_fire ? vec_onehot : 8'h00);
   assign edge_pend_next = (edge_pend_reg & ~edge_clr & trig_reg) | edge_set;

   // The ack sets ISR first, then EOI retires the highest-priority bit.
   assign isr_acked = isr_reg | (ack_fire ? vec_onehot : 8'h00);
   assign isr_next  = eoi ? (isr_acked & ~(isr_acked & (~isr_acked + 8'd1)))
                          : isr_acked;

   assign imr_next     = (wr_en && addr == 3'd0) ? data_in    : imr_reg;
   assign trig_next    = (wr_en && addr == 3'd3) ? data_in    : trig_reg;
   assign ctrl_en_next = (wr_en && addr == 3'd6) ? data_in[0] : ctrl_en_reg;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= 8'h00;
         s_prev_reg    <= 8'h00;
         imr_reg       <= 8'h00;
         trig_reg      <= 8'hFF;
         ctrl_en_reg   <= 1'b0;
         edge_pend_reg <= 8'h00;
         isr_reg       <= 8'h00;
         state_reg     <= ST_IDLE;
         cpu_irq_reg   <= 1'b0;
         vector_reg    <= 3'd0;
      end else begin
         sync_reg[0] <= irq_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
         s_prev_reg    <= s;
         imr_reg       <= imr_next;
         trig_reg      <= trig_next;
         ctrl_en_reg   <= ctrl_en_next;
         edge_pend_reg <= edge_pend_next;
         isr_reg       <= isr_next;
         state_reg     <= state_next;
         cpu_irq_reg   <= cpu_irq_next;
         vector_reg    <= vector_next;
      end
   end

   // Next-state logic. A request is withdrawn when its own line stops being
   // eligible; a higher-priority arrival just retargets the vector.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (eligible) state_next = ST_REQ;
         ST_REQ: begin
            if (cpu_ack)                 state_next = ST_IDLE;
            else if (!elig[vector_reg])  state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output logic feeding the registered cpu_irq / vector.
   always_comb begin
      cpu_irq_next = (state_next == ST_REQ);
      vector_next  = vector_reg;
      if (state_reg == ST_IDLE && eligible)
         vector_next = best;
      else if (state_reg == ST_REQ && !cpu_ack && elig[vector_reg])
         vector_next = best;
   end

   assign cpu_irq = cpu_irq_reg;
   assign vector  = vector_reg;

   always_comb begin
      data_out = 8'h00;
      case (addr)
         3'd0: data_out = imr_reg;
         3'd1: data_out = pending;
         3'd2: data_out = isr_reg;
         3'd3: data_out = trig_reg;
         3'd5: data_out = {5'b0, vector_reg};
         3'd6: data_out = {7'b0, ctrl_en_reg};
         default: data_out = 8'h00;
      endcase
   end

   // Reads have no side effects.
   logic unused_read;
   assign unused_read = read;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] addr = 3'd0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic       cs = 1'b0;
   logic [7:0] irq_in = 8'h00;
   logic       cpu_irq;
   logic       cpu_ack = 1'b0;
   logic [2:0] vector;

   int checks = 0;
   int errors = 0;

   interrupt_controller #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
      .data_out(data_out), .read(read), .write(write), .cs(cs),
      .irq_in(irq_in), .cpu_irq(cpu_irq), .cpu_ack(cpu_ack), .vector(vector)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } reg_vec_t;

   reg_vec_t tbl [19];

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end else begin
         $display("check %s: 0x%02h ok", name, act);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; write = 1'b1; addr = a; data_in = d;
      step();
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
      addr = a; read = 1'b1;
      #1;
      chk(name, data_out, exp);
      read = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] lines);
      irq_in = lines;
      step();
      irq_in = 8'h00;
   endtask

   task automatic ack();
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
   endtask

   // Bounded wait for cpu_irq; a timeout counts as a failed check.
   task automatic wait_irq(input string name);
      int n;
      n = 0;
      while (cpu_irq !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk(name, {7'b0, cpu_irq}, 8'h01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00};
      tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'h00};
      tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'hFF};
      tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'h00};
      tbl[5]  = '{1'b0, 3'd5, 8'h00, 8'h00};
      tbl[6]  = '{1'b0, 3'd6, 8'h00, 8'h00};
      tbl[7]  = '{1'b0, 3'd7, 8'h00, 8'h00};
      tbl[8]  = '{1'b1, 3'd0, 8'hA5, 8'hA5};
      tbl[9]  = '{1'b1, 3'd6, 8'hFF, 8'h01};
      tbl[10] = '{1'b1, 3'd3, 8'h0F, 8'h0F};
      tbl[11] = '{1'b1, 3'd2, 8'hFF, 8'h00};
      tbl[12] = '{1'b1, 3'd7, 8'hFF, 8'h00};
      tbl[13] = '{1'b1, 3'd4, 8'hFF, 8'h00};
      tbl[14] = '{1'b1, 3'd1, 8'hFF, 8'h00};
      tbl[15] = '{1'b1, 3'd5, 8'h07, 8'h00};
      tbl[16] = '{1'b1, 3'd0, 8'h00, 8'h00};
      tbl[17] = '{1'b1, 3'd6, 8'h00, 8'h00};
      tbl[18] = '{1'b1, 3'd3, 8'hFF, 8'hFF};

      repeat (3) @(posedge clk);
      #2;
      chk("reset_cpu_irq", {7'b0, cpu_irq}, 8'h00);
      chk("reset_vector", {5'b0, vector}, 8'h00);
      rst_n = 1'b1;
      step();

      // Register access table
      for (int i = 0; i < 19; i++) begin
         if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
         rd_chk($sformatf("reg_tbl%0d_a%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
      end

      // 1: single edge pulse on line 0, exact latency
      wr(3'd0, 8'h01);
      wr(3'd6, 8'h01);
      pulse(8'h01);                                   // edge 1
      chk("t1_e1_irq", {7'b0, cpu_irq}, 8'h00);
      step();                                         // edge 2
      chk("t1_e2_irq", {7'b0, cpu_irq}, 8'h00);
      step();                                         // edge 3
      chk("t1_e3_irq", {7'b0, cpu_irq}, 8'h00);
      rd_chk("t1_pending", 3'd1, 8'h01);
      step();                                         // edge 4
      chk("t1_e4_irq", {7'b0, cpu_irq}, 8'h01);
      chk("t1_vector", {5'b0, vector}, 8'h00);
      ack();
      chk("t1_ack_irq", {7'b0, cpu_irq}, 8'h00);
      rd_chk("t1_isr", 3'd2, 8'h01);
      rd_chk("t1_pend_clr", 3'd1, 8'h00);
      wr(3'd4, 8'h00);
      rd_chk("t1_eoi_isr", 3'd2, 8'h00);

      // 2: lines 5 and 2 together; 5 waits for EOI of 2
      wr(3'd0, 8'hFF);
      pulse(8'h24);
      wait_irq("t2_irq");
      chk("t2_vector", {5'b0, vector}, 8'h02);
      rd_chk("t2_vecreg", 3'd5, 8'h02);
      rd_chk("t2_pending", 3'd1, 8'h24);
      ack();
      rd_chk("t2_isr", 3'd2, 8'h04);
      rd_chk("t2_pend5", 3'd1, 8'h20);
      repeat (4) step();
      chk("t2_blocked_irq", {7'b0, cpu_irq}, 8'h00);
      wr(3'd4, 8'h00);
      rd_chk("t2_eoi_isr", 3'd2, 8'h00);
      chk("t2_eoi_edge_irq", {7'b0, cpu_irq}, 8'h00);
      step();
      chk("t2_line5_irq", {7'b0, cpu_irq}, 8'h01);
      chk("t2_line5_vec", {5'b0, vector}, 8'h05);
      ack();
      rd_chk("t2_isr5", 3'd2, 8'h20);
      wr(3'd4, 8'h00);
      rd_chk("t2_isr_clear", 3'd2, 8'h00);

      // 3: nesting, line 1 preempts in-service line 4
      pulse(8'h10);
      wait_irq("t3_irq4");
      chk("t3_vec4", {5'b0, vector}, 8'h04);
      ack();
      rd_chk("t3_isr10", 3'd2, 8'h10);
      pulse(8'h02);
      wait_irq("t3_irq1");
      chk("t3_vec1", {5'b0, vector}, 8'h01);
      ack();
      rd_chk("t3_isr12", 3'd2, 8'h12);
      wr(3'd4, 8'h00);
      rd_chk("t3_eoi1", 3'd2, 8'h10);
      wr(3'd4, 8'h00);
      rd_chk("t3_eoi2", 3'd2, 8'h00);

      // 4: level line 3 drops before ack
      wr(3'd3, 8'hF7);
      irq_in = 8'h08;
      wait_irq("t4_irq");
      chk("t4_vec", {5'b0, vector}, 8'h03);
      rd_chk("t4_pending", 3'd1, 8'h08);
      irq_in = 8'h00;
      repeat (4) step();
      chk("t4_drop_irq", {7'b0, cpu_irq}, 8'h00);
      rd_chk("t4_isr", 3'd2, 8'h00);
      rd_chk("t4_pend0", 3'd1, 8'h00);
      ack();
      rd_chk("t4_idle_ack_isr", 3'd2, 8'h00);
      chk("t4_idle_ack_irq", {7'b0, cpu_irq}, 8'h00);
      wr(3'd3, 8'hFF);

      // 5: masked edge on line 6, W1C, then W1C colliding with a new edge
      wr(3'd0, 8'h00);
      pulse(8'h40);
      repeat (3) step();
      rd_chk("t5_pending", 3'd1, 8'h40);
      chk("t5_irq", {7'b0, cpu_irq}, 8'h00);
      wr(3'd1, 8'h40);
      rd_chk("t5_w1c", 3'd1, 8'h00);
      pulse(8'h40);
      step();
      wr(3'd1, 8'h40);                               // lands on the set edge
      rd_chk("t5_set_wins", 3'd1, 8'h40);
      wr(3'd1, 8'h40);
      rd_chk("t5_w1c2", 3'd1, 8'h00);

      // 6: async reset mid-handshake
      wr(3'd0, 8'h05);
      wr(3'd3, 8'hC5);
      pulse(8'h04);
      wait_irq("t6_irq2");
      ack();
      pulse(8'h41);
      wait_irq("t6_irq0");
      chk("t6_vec0", {5'b0, vector}, 8'h00);
      rd_chk("t6_isr_pre", 3'd2, 8'h04);
      rd_chk("t6_pend_pre", 3'd1, 8'h41);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_irq", {7'b0, cpu_irq}, 8'h00);
      rd_chk("t6_imr", 3'd0, 8'h00);
      rd_chk("t6_trig", 3'd3, 8'hFF);
      rd_chk("t6_isr", 3'd2, 8'h00);
      rd_chk("t6_pending", 3'd1, 8'h00);
      rd_chk("t6_ctrl", 3'd6, 8'h00);
      chk("t6_vector", {5'b0, vector}, 8'h00);
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("t6_post_irq", {7'b0, cpu_irq}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
